// File: rtl/pcie_noc_bridge.sv
// Bridges PCIe words and a 2D-mesh NoC: ingress splits each PCIe word into
// addressed NoC packets, egress packs ejected NoC payloads back into PCIe words.
module pcie_noc_bridge #(
  parameter int X       = 4,
  parameter int Y       = 4,
  parameter int DATA_W  = 32,
  parameter int PCI_W   = 256,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64,
  localparam int XW      = (X > 1) ? $clog2(X) : 1,
  localparam int YW      = (Y > 1) ? $clog2(Y) : 1,
  localparam int TOTAL_W = DATA_W + XW + YW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic               i_valid_pci,
  input  logic [PCI_W-1:0]   i_data_pci,
  output logic               o_ready_pci,
  output logic               o_valid_pci,
  output logic [PCI_W-1:0]   o_data_pci,
  input  logic               i_ready_pci,
  output logic               o_valid_noc,
  output logic [TOTAL_W-1:0] o_data_noc,
  input  logic               i_ready_noc,
  input  logic               i_valid_noc,
  input  logic [TOTAL_W-1:0] i_data_noc,
  output logic               o_ready_noc
);
  localparam int BEATS = PCI_W / DATA_W;
  localparam int NODES = X * Y;
  localparam int DW    = $clog2(NODES);
  localparam int BW    = $clog2(BEATS);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW    = $clog2(BEATS + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [PCI_W-1:0]  word;
  logic              word_mode;
  logic [BW-1:0]     beat;
  logic [DW-1:0]     dest;
  logic              last_beat;
  logic              pci_accept;
  logic              noc_hs;
  logic [XW-1:0]     dest_x;
  logic [YW-1:0]     dest_y;
  logic [31:0]       dest_ext;
  logic [DATA_W-1:0] lane;

  assign last_beat   = (beat == BW'(BEATS - 1));
  assign o_ready_pci = !rst && ((state == IDLE) || (last_beat && i_ready_noc));
  assign o_valid_noc = !rst && (state == SEND);
  assign pci_accept  = i_valid_pci && o_ready_pci;
  assign noc_hs      = o_valid_noc && i_ready_noc;
  assign lane        = word[beat*DATA_W +: DATA_W];
  assign o_data_noc  = rst ? '0 : {dest_y, dest_x, lane};

  // Header mode takes {y,x} from lane 0 of the held word; round-robin maps d onto the mesh.
  always_comb begin
    dest_ext = 32'(dest);
    if (word_mode) begin
      dest_x = word[XW-1:0];
      dest_y = word[XW+YW-1:XW];
    end else begin
      dest_x = XW'(dest_ext % 32'(X));
      dest_y = YW'(dest_ext / 32'(X));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      word      <= '0;
      word_mode <= 1'b0;
      beat      <= '0;
      dest      <= DW'(1);
    end else begin
      if (noc_hs && !word_mode)
        dest <= (dest == DW'(NODES - 1)) ? DW'(1) : dest + DW'(1);
      if (pci_accept) begin
        word      <= i_data_pci;
        word_mode <= mode;
        beat      <= mode ? BW'(1) : '0;
        state     <= SEND;
      end else if (noc_hs) begin
        if (last_beat)
          state <= IDLE;
        else
          beat <= beat + BW'(1);
      end
    end
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       count;
  logic [PCI_W-1:0]  pack;
  logic [FW-1:0]     fill;
  logic [TW-1:0]     idle;
  logic              pci_valid;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              pci_hs;
  logic              unused_noc_hdr;

  assign full           = (count == (AW+1)'(DEPTH));
  assign empty          = (count == '0);
  assign o_ready_noc    = !rst && !full;
  assign push           = i_valid_noc && o_ready_noc;
  assign pop            = !empty && !pci_valid && (fill != FW'(BEATS));
  assign pci_hs         = pci_valid && i_ready_pci;
  assign o_valid_pci    = !rst && pci_valid;
  assign o_data_pci     = rst ? '0 : pack;
  assign unused_noc_hdr = ^i_data_noc[TOTAL_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= i_data_noc[DATA_W-1:0];
  end

  // Packer: lanes not yet filled stay zero because pack is cleared on every hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      pack      <= '0;
      fill      <= '0;
      idle      <= '0;
      pci_valid <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (pci_hs) begin
        pci_valid <= 1'b0;
        fill      <= '0;
        pack      <= '0;
        idle      <= '0;
      end else if (pop) begin
        pack[fill*DATA_W +: DATA_W] <= mem[rptr];
        fill <= fill + FW'(1);
        idle <= '0;
      end else if (!pci_valid && fill == FW'(BEATS)) begin
        pci_valid <= 1'b1;
      end else if (!pci_valid && fill != '0 && empty) begin
        if (idle == TW'(TIMEOUT - 1)) begin
          pci_valid <= 1'b1;
          idle      <= '0;
        end else begin
          idle <= idle + TW'(1);
        end
      end
    end
  end

endmodule

// File: doc/pcie_noc_bridge.md
PCIE_NOC_BRIDGE -- requirements
Module: pcie_noc_bridge

Interface
REQ-001 The block SHALL have parameter X, default 4, meaning mesh columns (>=1).
REQ-002 The block SHALL have parameter Y, default 4, meaning mesh rows (>=1); X*Y >= 2.
REQ-003 The block SHALL have parameter DATA_W, default 32, meaning NoC payload width.
REQ-004 The block SHALL have parameter PCI_W, default 256, meaning PCIe word width; BEATS = PCI_W/DATA_W, an integer >= 2.
REQ-005 The block SHALL have parameter DEPTH, default 8, meaning egress FIFO entries (power of 2, >= 2).
REQ-006 The block SHALL have parameter TIMEOUT, default 64, meaning idle cycles before a partial egress word is flushed (>= 1).
REQ-007 Derived widths SHALL be XW = max(1, clog2(X)), YW = max(1, clog2(Y)) and TOTAL_W = DATA_W+XW+YW; packet = {y[YW], x[XW], data[DATA_W]}, data in the LSBs.
REQ-008 The ports SHALL be as follows:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- mode  in  1  0 = round-robin destination; 1 = header-addressed.
- i_valid_pci / i_data_pci / o_ready_pci  in/in/out  1/PCI_W/1  PCIe ingress.
- o_valid_pci / o_data_pci / i_ready_pci  out/out/in  1/PCI_W/1  PCIe egress.
- o_valid_noc / o_data_noc / i_ready_noc  out/out/in  1/TOTAL_W/1  NoC injection.
- i_valid_noc / i_data_noc / o_ready_noc  in/in/out  1/TOTAL_W/1  NoC ejection.

Function
REQ-009 Every transfer SHALL complete on a cycle where valid & ready are both 1; a valid output and its data SHALL hold stable until that cycle.
REQ-010 The ingress FSM SHALL have two states, IDLE and SEND; o_ready_pci = (IDLE) | (SEND & last beat & i_ready_noc).
REQ-011 On an ingress accept, the block SHALL register the word and mode, set the beat index to 0 (mode 0) or 1 (mode 1), and enter SEND; o_valid_noc SHALL rise the next cycle.
REQ-012 In SEND, o_data_noc data SHALL be lane[beat] = i_data_pci[beat*DATA_W +: DATA_W] of the held word; beat SHALL advance by 1 on each NoC handshake.
REQ-013 Last beat is BEATS-1; after its handshake the FSM SHALL return to IDLE, or stay in SEND with the new word if an accept occurs on the same cycle (zero-bubble).
REQ-014 In mode 0, dest index d SHALL start at 1, increment by 1 per NoC handshake, and wrap from X*Y-1 to 1 (node 0 is never addressed); x = d % X, y = d / X.
REQ-015 In mode 1, lane 0 SHALL be a header with {y,x} = lane0[XW+YW-1:0], used for all beats 1..BEATS-1 of that word, and lane 0 SHALL NOT be sent; d is unchanged.
REQ-016 Egress SHALL push i_data_noc[DATA_W-1:0] into the FIFO on an ejection handshake; o_ready_noc = !full, with the FIFO count taken from registers.
REQ-017 The packer SHALL pop one FIFO entry per cycle while the FIFO is not empty and o_valid_pci = 0, writing lane[fill], and then fill++.
REQ-018 When fill reaches BEATS, o_valid_pci SHALL assert the next cycle; on the PCIe handshake, fill = 0 and o_valid_pci = 0.
REQ-019 The idle counter SHALL reset on every pop and count while 0 < fill < BEATS with the FIFO empty; on reaching TIMEOUT, the block SHALL assert o_valid_pci with unfilled lanes = 0.
REQ-020 While o_valid_pci = 1, popping SHALL stall; FIFO pushes SHALL continue until full.
REQ-021 On a simultaneous push and pop, the FIFO count SHALL be unchanged; an entry pushed into an empty FIFO SHALL be poppable the following cycle.

Reset
REQ-022 While rst = 1, the block SHALL drive o_valid_noc, o_valid_pci, o_ready_pci, o_ready_noc, o_data_noc and o_data_pci to 0.
REQ-023 Reset SHALL force FSM = IDLE, d = 1, FIFO empty, fill = 0 and idle counter = 0; in-flight words and partial packs are discarded.
REQ-024 The cycle after rst falls, the block SHALL drive o_ready_pci = 1 and o_ready_noc = 1.

Verification (X=Y=2, DATA_W=32, PCI_W=256, DEPTH=8, TIMEOUT=4)
REQ-025 Mode 0, word lanes 0..7 = 0x10..0x17, i_ready_noc = 1 -> 8 beats on consecutive cycles starting 1 cycle after accept, dest (x,y) = (1,0), (0,1), (1,1), (1,0), ... ; a second word accepted on the last beat follows with no bubble.
REQ-026 Mode 1, lane0 = 0x3 and lanes 1..7 = 0xA1..0xA7 -> 7 beats, all to (1,1), lane 0 never emitted.
REQ-027 i_ready_noc toggling 1/0 -> each beat held stable while ready = 0, no beat lost or duplicated, and o_ready_pci = 0 until the last beat handshake.
REQ-028 8 ejections 0xB0..0xB7 -> o_data_pci = {0xB7,...,0xB0} (lane 0 = 0xB0); with i_ready_pci = 0, a further 8 pushes fill the FIFO and o_ready_noc drops on the 9th.
REQ-029 3 ejections then idle -> o_valid_pci asserts TIMEOUT cycles after the last pop with lanes 3..7 = 0.
REQ-030 rst pulsed mid-SEND at beat 4 and with fill = 5 -> the next cycle all outputs = 0; after release, no residual beats or PCIe word, and the next ingress word starts at d = 1.
